// File: rtl/enc83_evt.sv
// rtl/enc83_evt.sv - event-capturing 8-to-3 priority encoder with valid/ack handshake
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         capture enable; edges seen while low are dropped
//   i0..i7     request lines; a request is a 0->1 transition
//   ack        consumer accepts the presented code (only while v=1)
//   a, b, c    registered code of the presented request, a = MSB
//   v          registered valid
//   npend      popcount of the pending register (0..8)
//   ovf        sticky overflow, cleared only by rst
module enc83_evt (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       i4,
  input  logic       i5,
  input  logic       i6,
  input  logic       i7,
  input  logic       ack,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       v,
  output logic [3:0] npend,
  output logic       ovf
);

  logic [7:0] req;
  logic [7:0] prev;
  logic [7:0] pend;
  logic [7:0] req_edge;
  logic [7:0] cap;
  logic [7:0] clr;
  logic [2:0] out_code;
  logic [2:0] hi_idx;
  logic       load;

  assign req      = {i7, i6, i5, i4, i3, i2, i1, i0};
  assign req_edge = req & ~prev;
  assign cap      = {8{en}} & req_edge;

  // Load looks only at the registered pend; same-cycle edges wait a clock.
  assign load = (~v | ack) & (pend != 8'd0);

  // Ascending scan so the highest set index wins.
  always_comb begin
    hi_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (pend[k]) hi_idx = 3'(k);
    end
  end

  always_comb begin
    clr = 8'd0;
    if (load) clr[hi_idx] = 1'b1;
  end

  always_comb begin
    npend = 4'd0;
    for (int k = 0; k < 8; k++) begin
      npend = npend + {3'd0, pend[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= 8'd0;
      pend     <= 8'd0;
      out_code <= 3'd0;
      v        <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      prev <= req;
      // Set wins over clear so an edge on the line being loaded is kept.
      pend <= (pend & ~clr) | cap;
      // A line being cleared this cycle is free, so a new edge there is not an overflow.
      if ((cap & pend & ~clr) != 8'd0) ovf <= 1'b1;
      if (load) begin
        out_code <= hi_idx;
        v        <= 1'b1;
      end else if (v && ack) begin
        // Reached only when pend is empty; out_code keeps its last value.
        v <= 1'b0;
      end
    end
  end

  assign {a, b, c} = out_code;

endmodule

// File: tb/tb_enc83_evt.sv
// tb/tb_enc83_evt.sv - directed self-checking bench for enc83_evt
module tb_enc83_evt;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] iv;
  logic       ack;
  logic       a, b, c, v, ovf;
  logic [3:0] npend;
  logic [2:0] code;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign code = {a, b, c};

  enc83_evt dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .i0    (iv[0]),
    .i1    (iv[1]),
    .i2    (iv[2]),
    .i3    (iv[3]),
    .i4    (iv[4]),
    .i5    (iv[5]),
    .i6    (iv[6]),
    .i7    (iv[7]),
    .ack   (ack),
    .a     (a),
    .b     (b),
    .c     (c),
    .v     (v),
    .npend (npend),
    .ovf   (ovf)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    iv  = 8'h00;
    ack = 1'b0;

    // Reset / idle
    step();
    step();
    check("rst_code", int'(code), 0);
    check("rst_v", int'(v), 0);
    check("rst_npend", int'(npend), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("idle_v", int'(v), 0);
      check("idle_npend", int'(npend), 0);
    end

    // Single event on i5
    iv[5] = 1'b1;
    step();
    check("single_npend1", int'(npend), 1);
    check("single_v0", int'(v), 0);
    iv[5] = 1'b0;
    step();
    check("single_code", int'(code), 5);
    check("single_v1", int'(v), 1);
    check("single_npend0", int'(npend), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("single_hold_code", int'(code), 5);
      check("single_hold_v", int'(v), 1);
    end
    ack = 1'b1;
    step();
    check("single_ack_v", int'(v), 0);
    check("single_ack_code_kept", int'(code), 5);
    ack = 1'b0;

    // Priority and back-to-back with ack held
    ack = 1'b1;
    iv  = 8'b0100_1010;
    step();
    check("prio_npend3", int'(npend), 3);
    check("prio_v0", int'(v), 0);
    iv = 8'h00;
    step();
    check("prio_code6", int'(code), 6);
    check("prio_v6", int'(v), 1);
    step();
    check("prio_code3", int'(code), 3);
    step();
    check("prio_code1", int'(code), 1);
    check("prio_npend0", int'(npend), 0);
    step();
    check("prio_drain_v", int'(v), 0);

    // Pre-emption: i7 arrives while 011 is held
    iv = 8'b0100_1010;
    step();
    iv = 8'h00;
    step();
    check("pre_code6", int'(code), 6);
    step();
    check("pre_code3", int'(code), 3);
    ack   = 1'b0;
    iv[7] = 1'b1;
    step();
    check("pre_hold3a", int'(code), 3);
    check("pre_npend2", int'(npend), 2);
    iv[7] = 1'b0;
    step();
    check("pre_hold3b", int'(code), 3);
    ack = 1'b1;
    step();
    check("pre_code7", int'(code), 7);
    step();
    check("pre_code1", int'(code), 1);
    step();
    check("pre_drain_v", int'(v), 0);
    ack = 1'b0;

    // Enable gating
    en    = 1'b0;
    iv[2] = 1'b1;
    step();
    check("en0_npend", int'(npend), 0);
    step();
    check("en0_v", int'(v), 0);
    en = 1'b1;
    step();
    check("en1_level_npend", int'(npend), 0);
    step();
    check("en1_level_v", int'(v), 0);
    iv[2] = 1'b0;
    step();
    iv[2] = 1'b1;
    step();
    check("en1_edge_npend", int'(npend), 1);
    iv[2] = 1'b0;
    step();
    check("en1_code2", int'(code), 2);
    check("en1_v", int'(v), 1);
    ack = 1'b1;
    step();
    check("en1_ack_v", int'(v), 0);
    ack = 1'b0;

    // Set-wins: edge on i4 in the cycle pend[4] is loaded
    iv[7] = 1'b1;
    step();
    iv[7] = 1'b0;
    step();
    check("sw_code7", int'(code), 7);
    iv[4] = 1'b1;
    step();
    check("sw_npend1", int'(npend), 1);
    iv[4] = 1'b0;
    step();
    ack   = 1'b1;
    iv[4] = 1'b1;
    step();
    check("sw_code4", int'(code), 4);
    check("sw_pend4_kept", int'(npend), 1);
    check("sw_ovf0", int'(ovf), 0);
    ack   = 1'b0;
    iv[4] = 1'b0;
    step();
    check("sw_hold4", int'(code), 4);
    check("sw_npend_hold", int'(npend), 1);

    // Overflow: two pulses on i0 while 111 is held
    iv[7] = 1'b1;
    step();
    iv[7] = 1'b0;
    ack   = 1'b1;
    step();
    check("ovf_code7", int'(code), 7);
    check("ovf_npend_pre", int'(npend), 1);
    ack   = 1'b0;
    iv[0] = 1'b1;
    step();
    check("ovf_first_pulse", int'(ovf), 0);
    check("ovf_npend2", int'(npend), 2);
    iv[0] = 1'b0;
    step();
    iv[0] = 1'b1;
    step();
    check("ovf_second_pulse", int'(ovf), 1);
    iv[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ovf_sticky", int'(ovf), 1);
    end
    check("ovf_hold_code", int'(code), 7);

    // Reset mid-operation with npend=3 and v=1
    iv[5] = 1'b1;
    step();
    check("mid_npend3", int'(npend), 3);
    check("mid_v1", int'(v), 1);
    rst = 1'b1;
    step();
    check("mid_rst_v", int'(v), 0);
    check("mid_rst_npend", int'(npend), 0);
    check("mid_rst_ovf", int'(ovf), 0);
    check("mid_rst_code", int'(code), 0);
    rst = 1'b0;
    step();
    check("post_rst_npend", int'(npend), 1);
    step();
    check("post_rst_code", int'(code), 5);
    check("post_rst_v", int'(v), 1);
    iv = 8'h00;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
